// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator.
//   state_e          : FSM state encoding
//   REP_W / GAP_W    : repetition / gap counter widths
//   BIT_W            : bit-position counter width (covers PAT_W up to 8)
//   DEFAULT_PATTERN  : built-in pattern sent when use_default=1
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int REP_W = 4;
  localparam int GAP_W = 3;
  localparam int BIT_W = 3;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_shifter.sv
// MSB-first load/shift register for the serial pattern.
// Ports:
//   clock, reset_n : clock and async active-low reset (clears the register)
//   load_i         : load data_i (takes priority over shift_i)
//   shift_i        : shift one position towards the MSB, zero fill
//   data_i         : parallel pattern to load
//   msb_o          : current MSB, i.e. the bit being presented
module seq_shifter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern burst generator.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; captures pattern, reps, gap_len
//   ST_SHIFT | presenting one pattern bit per cycle, MSB first
//   ST_GAP   | idle cycles between repetitions
//   ST_DONE  | one-cycle completion pulse, then back to idle
//
// Ports:
//   clock, reset_n : clock and async active-low reset
//   start          : begin a burst (sampled only in idle)
//   use_default    : 1 sends PATTERN, 0 sends pattern_in
//   pattern_in     : user pattern, MSB first
//   reps           : repetitions 0..15 (0 goes straight to done)
//   gap_len        : idle cycles between repetitions 0..7
//   abort          : cancel the burst in shift/gap, no done pulse
//   sequence_out   : serial data, 0 when bit_valid=0
//   bit_valid      : sequence_out carries a pattern bit
//   busy           : high in shift and gap
//   done           : one-cycle pulse on normal completion
module seq_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gcfg_q, gcfg_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BIT_W-1:0]   bit_q, bit_d;

  logic               sh_load, sh_shift, sh_msb;
  logic [PAT_W-1:0]   sh_data, pat_sel;

  assign pat_sel = use_default ? PATTERN : pattern_in;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    rep_d    = rep_q;
    gcfg_d   = gcfg_q;
    gap_d    = gap_q;
    bit_d    = bit_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = pat_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          pat_d  = pat_sel;
          rep_d  = reps;
          gcfg_d = gap_len;
          if (reps == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
            sh_load = 1'b1;
            sh_data = pat_sel;
            bit_d   = BIT_LAST;
          end
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_q == '0) begin
          // rep_q counts repetitions still owed, including the current one
          if (rep_q <= REP_W'(1)) begin
            rep_d   = '0;
            state_d = ST_DONE;
          end else begin
            rep_d = rep_q - REP_W'(1);
            if (gcfg_q == '0) begin
              sh_load = 1'b1;
              bit_d   = BIT_LAST;
            end else begin
              state_d = ST_GAP;
              gap_d   = gcfg_q - GAP_W'(1);
            end
          end
        end else begin
          sh_shift = 1'b1;
          bit_d    = bit_q - BIT_W'(1);
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          state_d = ST_SHIFT;
          sh_load = 1'b1;
          bit_d   = BIT_LAST;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gcfg_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gcfg_q  <= gcfg_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
    end
  end

  seq_shifter #(.W(PAT_W)) u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .msb_o   (sh_msb)
  );

  // Outputs decode flops only: no combinational path from any input.
  assign bit_valid    = (state_q == ST_SHIFT);
  assign sequence_out = bit_valid & sh_msb;
  assign busy         = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign done         = (state_q == ST_DONE);

endmodule
